// File: rtl/cpu_sequencer.sv
// Fetch/execute controller for the 16-bit CPU: fetches into IR', strobes the ALU, owns CARRY/SKIP.
// Optional HALT state on IR'=16'h4000 is enabled by defining SEQ_HALT_EN.
module cpu_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       instruction,
    output logic              exec1,
    input  logic              carryout,
    input  logic              carryen,
    input  logic              skipout,
    input  logic              skipen,
    output logic              carrystatus,
    output logic              skipstatus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

`ifdef SEQ_HALT_EN
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC1 = 2'd1, S_HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC1 = 2'd1} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              carry_q, carry_d;
    logic              skip_q, skip_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
            ir_q    <= 16'h0000;
            carry_q <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        skip_d  = skip_q;
        mem_req = 1'b0;
        exec1   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d = mem_rdata;
                    pc_d = pc_q + 1'b1;
                    // A pending skip consumes this word without ever strobing the ALU.
                    if (skip_q) skip_d = 1'b0;
                    else        state_d = S_EXEC1;
                end
            end
            S_EXEC1: begin
                exec1   = 1'b1;
                state_d = S_FETCH;
                if (carryen) carry_d = carryout;
                if (skipen)  skip_d  = skipout;
                // JMP overrides the increment already applied during FETCH.
                if (ir_q[15:14] == 2'b00) pc_d = ir_q[ADDR_W-1:0];
`ifdef SEQ_HALT_EN
                if (ir_q == 16'h4000) state_d = S_HALT;
`endif
            end
`ifdef SEQ_HALT_EN
            S_HALT: ;
`endif
            default: state_d = S_FETCH;
        endcase
    end

`ifdef SEQ_HALT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instruction = ir_q;
    assign carrystatus = carry_q;
    assign skipstatus  = skip_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction-level model checked every cycle plus literal checkpoints.
module tb_cpu_sequencer;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] mem_addr, pc;
    logic          mem_req, mem_ready, exec1, halted;
    logic [15:0]   mem_rdata, instruction;
    logic          carryout, carryen, skipout, skipen, carrystatus, skipstatus;
    logic [15:0]   mem [256];

    int nvec = 0;
    int nerr = 0;

    cpu_sequencer #(.ADDR_W(AW), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instruction(instruction),
        .exec1(exec1), .carryout(carryout), .carryen(carryen), .skipout(skipout),
        .skipen(skipen), .carrystatus(carrystatus), .skipstatus(skipstatus),
        .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_ready ? mem[mem_addr] : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: what the sequencer must show this cycle, updated from
    // the inputs seen at mid-cycle for the coming edge.
    logic [AW-1:0] m_pc;
    logic [15:0]   m_ir;
    bit            m_exec, m_carry, m_skip, m_halt;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_pc = '0; m_ir = '0; m_exec = 0; m_carry = 0; m_skip = 0; m_halt = 0;
            end else begin
                chk("exec1",   32'(exec1),       32'(m_exec));
                chk("mem_req", 32'(mem_req),     32'(!m_exec && !m_halt));
                chk("addr",    32'(mem_addr),    32'(m_pc));
                chk("pc",      32'(pc),          32'(m_pc));
                chk("ir",      32'(instruction), 32'(m_ir));
                chk("carry",   32'(carrystatus), 32'(m_carry));
                chk("skip",    32'(skipstatus),  32'(m_skip));
                chk("halted",  32'(halted),      32'(m_halt));
                if (m_halt) begin
                end else if (m_exec) begin
                    m_exec = 0;
                    if (carryen) m_carry = carryout;
                    if (skipen)  m_skip  = skipout;
                    if (m_ir[15:14] == 2'b00) m_pc = m_ir[AW-1:0];
`ifdef SEQ_HALT_EN
                    if (m_ir == 16'h4000) m_halt = 1;
`endif
                end else if (mem_ready) begin
                    m_ir = mem_rdata;
                    m_pc = m_pc + 1'b1;
                    if (m_skip) m_skip = 0;
                    else        m_exec = 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, nerr=%0d", nerr);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
    endtask

    // Leaves the caller one step after a rising edge, in the first FETCH cycle.
    task automatic do_reset;
        reset = 1'b1;
        carryen = 0; carryout = 0; skipen = 0; skipout = 0; mem_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",    32'(pc),          32'h0);
        chk("rst_ir",    32'(instruction), 32'h0);
        chk("rst_carry", 32'(carrystatus), 32'h0);
        chk("rst_skip",  32'(skipstatus),  32'h0);
        chk("rst_exec1", 32'(exec1),       32'h0);
        chk("rst_req",   32'(mem_req),     32'h1);
        chk("rst_halt",  32'(halted),      32'h0);
        reset = 1'b0;
    endtask

    initial begin
        bit found;
        reset = 1'b1;

        // 1: zero-wait fetch/execute cadence
        clear_mem(); mem[0] = 16'hC010;
        do_reset();
        chk("t1_req_c1", 32'(mem_req), 32'h1);
        tick();
        chk("t1_exec_c2", 32'(exec1), 32'h1);
        chk("t1_ir_c2",   32'(instruction), 32'hC010);
        chk("t1_pc_c2",   32'(pc), 32'h1);
        tick();
        chk("t1_req_c3",  32'(mem_req), 32'h1);
        tick();
        chk("t1_pc_c4",   32'(pc), 32'h2);

        // 2: three wait cycles; carry enable outside EXEC1 must be ignored
        clear_mem(); mem[0] = 16'hC020;
        do_reset();
        mem_ready = 0; carryen = 1; carryout = 1;
        chk("t2_addr_c1", 32'(mem_addr), 32'h0);
        repeat (3) begin
            tick();
            chk("t2_addr_wait",  32'(mem_addr), 32'h0);
            chk("t2_exec_wait",  32'(exec1), 32'h0);
            chk("t2_carry_wait", 32'(carrystatus), 32'h0);
        end
        mem_ready = 1; carryen = 0;
        tick();
        chk("t2_exec", 32'(exec1), 32'h1);
        chk("t2_ir",   32'(instruction), 32'hC020);
        tick();
        chk("t2_noexec", 32'(exec1), 32'h0);

        // 3: skip discards the next word
        clear_mem(); mem[0] = 16'hC000; mem[1] = 16'hC030; mem[2] = 16'hC040;
        do_reset();
        tick();
        skipen = 1; skipout = 1;
        chk("t3_exec0", 32'(exec1), 32'h1);
        tick();
        skipen = 0; skipout = 0;
        chk("t3_skip_set", 32'(skipstatus), 32'h1);
        chk("t3_addr1",    32'(mem_addr), 32'h1);
        tick();
        chk("t3_no_exec",  32'(exec1), 32'h0);
        chk("t3_skip_clr", 32'(skipstatus), 32'h0);
        chk("t3_pc2",      32'(pc), 32'h2);
        tick();
        chk("t3_exec2", 32'(exec1), 32'h1);
        chk("t3_ir2",   32'(instruction), 32'hC040);
        chk("t3_pc3",   32'(pc), 32'h3);

        // 4: absolute jump, then wrap from 8'hFF
        clear_mem(); mem[5] = 16'h0012; mem[8'h12] = 16'h00FF;
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (exec1 && instruction == 16'h0012) found = 1;
        end
        chk("t4_jmp_seen", 32'(found), 32'h1);
        tick();
        chk("t4_pc_jmp",   32'(pc), 32'h12);
        chk("t4_addr_jmp", 32'(mem_addr), 32'h12);
        tick();
        chk("t4_ir_ff", 32'(instruction), 32'h00FF);
        chk("t4_pc_13", 32'(pc), 32'h13);
        tick();
        chk("t4_pc_ff", 32'(pc), 32'hFF);
        tick();
        chk("t4_wrap",  32'(pc), 32'h00);
        chk("t4_exec",  32'(exec1), 32'h1);

        // 5: carry set, then asynchronous reset mid-FETCH
        clear_mem(); mem[0] = 16'hC000;
        do_reset();
        tick();
        carryen = 1; carryout = 1;
        tick();
        carryen = 0; carryout = 0; mem_ready = 0;
        chk("t5_carry", 32'(carrystatus), 32'h1);
        repeat (2) tick();
        chk("t5_carry_hold", 32'(carrystatus), 32'h1);
        chk("t5_pc_hold",    32'(pc), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_carry", 32'(carrystatus), 32'h0);
        chk("t5_async_pc",    32'(pc), 32'h0);
        chk("t5_async_req",   32'(mem_req), 32'h1);
        tick();
        reset = 1'b0; mem_ready = 1;

        // 6: 16'h4000 halts with the option, otherwise a NOP
        clear_mem(); mem[0] = 16'h4000; mem[1] = 16'hC050;
        do_reset();
        tick();
        chk("t6_exec", 32'(instruction), 32'h4000);
        tick();
`ifdef SEQ_HALT_EN
        repeat (20) begin
            chk("t6_halted", 32'(halted), 32'h1);
            chk("t6_req",    32'(mem_req), 32'h0);
            chk("t6_exec1",  32'(exec1), 32'h0);
            chk("t6_pc",     32'(pc), 32'h1);
            tick();
        end
`else
        chk("t6_halted", 32'(halted), 32'h0);
        chk("t6_req",    32'(mem_req), 32'h1);
        chk("t6_addr",   32'(mem_addr), 32'h1);
        tick();
        chk("t6_next",   32'(instruction), 32'hC050);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
